// File: rtl/spi_ram_arbiter_if.sv
// Bus bundle between the CPU's two memory ports, the arbiter and the
// SPI RAM controller. The slave modport is the arbiter's view; the master
// modport is the view of everything around it (CPU ports plus controller).
interface spi_ram_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 16
);
  // Instruction-fetch port (read-only)
  logic                  fetch_req;
  logic [ADDR_BITS-1:0]  fetch_addr;
  logic                  fetch_ack;
  // Load/store data port
  logic                  data_req;
  logic                  data_we;
  logic [ADDR_BITS-1:0]  data_addr;
  logic [DATA_WIDTH-1:0] data_wdata;
  logic                  data_ack;
  // Shared read data back to the CPU
  logic [DATA_WIDTH-1:0] rdata;
  // SPI RAM controller side
  logic [ADDR_BITS-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_start_read;
  logic                  mem_start_write;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_busy;

  modport slave (
    input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
           mem_rdata, mem_busy,
    output fetch_ack, data_ack, rdata, mem_addr, mem_wdata,
           mem_start_read, mem_start_write
  );

  modport master (
    output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
           mem_rdata, mem_busy,
    input  fetch_ack, data_ack, rdata, mem_addr, mem_wdata,
           mem_start_read, mem_start_write
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Two-port arbiter in front of a single SPI RAM controller.
// One transaction at a time: latch winner in IDLE, pulse start in ISSUE,
// wait for busy to drop in WAIT, ack the winner in DONE.
// Optional macro RR_ARB_EN: round-robin between the ports on simultaneous
// requests; without it the data port always has priority over fetch.
module spi_ram_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 16
) (
  input logic               clk,
  input logic               rst,
  spi_ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic       {G_FETCH, G_DATA} port_t;

  state_t                state_q, state_d;
  port_t                 grant_q, winner;
  logic                  op_write_q;
  logic [ADDR_BITS-1:0]  mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  any_req;

  assign any_req = bus.fetch_req | bus.data_req;

`ifdef RR_ARB_EN
  port_t last_grant_q;

  // Round-robin pick: on a tie, the port that did not win last time goes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    winner = G_FETCH;
    if (bus.fetch_req && bus.data_req)
      winner = (last_grant_q == G_DATA) ? G_FETCH : G_DATA;
    else if (bus.data_req)
      winner = G_DATA;
  end

  // Remember who was served, updated as each transaction completes.
  always_ff @(posedge clk) begin
    if (rst)
      last_grant_q <= G_FETCH;
    else if (state_q == S_DONE)
      last_grant_q <= grant_q;
  end
`else
  // Fixed priority pick: the data port beats fetch.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    winner = G_FETCH;
    if (bus.data_req)
      winner = G_DATA;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. IDLE refuses to start while the controller still
  // claims to be busy; that only happens after a protocol error.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req && !bus.mem_busy) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (!bus.mem_busy) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Transaction latch in IDLE and read-data capture at the end of WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q     <= G_FETCH;
      op_write_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      if (state_q == S_IDLE && any_req && !bus.mem_busy) begin
        grant_q <= winner;
        if (winner == G_DATA) begin
          op_write_q  <= bus.data_we;
          mem_addr_q  <= bus.data_addr;
          mem_wdata_q <= bus.data_wdata;
        end else begin
          op_write_q  <= 1'b0;
          mem_addr_q  <= bus.fetch_addr;
        end
      end
      if (state_q == S_WAIT && !bus.mem_busy && !op_write_q)
        rdata_q <= bus.mem_rdata;
    end
  end

  // Start pulses exist only in ISSUE; acks only in DONE, to the winner.
  assign bus.mem_start_read  = (state_q == S_ISSUE) && !op_write_q;
  assign bus.mem_start_write = (state_q == S_ISSUE) &&  op_write_q;
  assign bus.fetch_ack       = (state_q == S_DONE) && (grant_q == G_FETCH);
  assign bus.data_ack        = (state_q == S_DONE) && (grant_q == G_DATA);
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.rdata           = rdata_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a behavioural SPI RAM controller
// (busy for 40 cycles per access). Define RR_ARB_EN to check round-robin.
module tb_spi_ram_arbiter;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int N  = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) bus ();

  spi_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- controller model ----------------
  logic [DW-1:0] mem_model [0:65535];
  int   cnt = 0;
  logic busy_force = 1'b0;

  assign bus.mem_busy = (cnt != 0) || busy_force;

  always @(posedge clk) begin
    if (rst) begin
      cnt <= 0;
      mem_model[16'h0100] <= 16'hBEEF;
      mem_model[16'h0300] <= 16'h5A5A;
    end else if (bus.mem_start_read) begin
      cnt <= N;
      bus.mem_rdata <= mem_model[bus.mem_addr];
    end else if (bus.mem_start_write) begin
      cnt <= N;
      mem_model[bus.mem_addr] <= bus.mem_wdata;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
    end
  end

  // ---------------- protocol monitor ----------------
  int rd_pulses = 0, wr_pulses = 0, ack_cnt = 0, viol = 0;
  logic [DW-1:0] wdata_at_start = '0;

  always @(negedge clk) begin
    if (bus.mem_start_read)  rd_pulses++;
    if (bus.mem_start_write) begin
      wr_pulses++;
      wdata_at_start = bus.mem_wdata;
    end
    if (bus.fetch_ack || bus.data_ack) ack_cnt++;
    if ((bus.mem_start_read && bus.mem_start_write) ||
        ((bus.mem_start_read || bus.mem_start_write) && bus.mem_busy))
      viol++;
  end

  // Counts negedges until the wanted ack; flags the other port's ack.
  task automatic wait_ack(input bit want_data, output int cyc, output bit wrong);
    cyc = 0;
    wrong = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (want_data ? bus.fetch_ack : bus.data_ack) wrong = 1'b1;
      if (want_data ? bus.data_ack : bus.fetch_ack) break;
      if (cyc >= 200) break;
    end
  endtask

  initial begin
    int  cyc, rd0, wr0, a0;
    bit  wrong, who;
    bit  exp_who;

    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.data_req   = 1'b0;
    bus.data_we    = 1'b0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_fetch_ack", bus.fetch_ack, 0);
    check("rst_data_ack",  bus.data_ack, 0);
    check("rst_start",     {bus.mem_start_read, bus.mem_start_write}, 0);
    check("rst_rdata",     bus.rdata, 0);
    check("rst_mem_addr",  bus.mem_addr, 0);
    rst = 1'b0;

    // Single fetch of 0x0100
    @(negedge clk);
    rd0 = rd_pulses; wr0 = wr_pulses;
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'h0100;
    wait_ack(1'b0, cyc, wrong);
    bus.fetch_req = 1'b0;
    check("fetch_latency", cyc, 43);
    check("fetch_no_data_ack", wrong, 0);
    check("fetch_rdata", bus.rdata, 16'hBEEF);
    check("fetch_rd_pulses", rd_pulses - rd0, 1);
    check("fetch_wr_pulses", wr_pulses - wr0, 0);

    // Data write 0x1234 to 0x0200
    @(negedge clk);
    rd0 = rd_pulses; wr0 = wr_pulses;
    bus.data_req = 1'b1; bus.data_we = 1'b1;
    bus.data_addr = 16'h0200; bus.data_wdata = 16'h1234;
    wait_ack(1'b1, cyc, wrong);
    bus.data_req = 1'b0;
    check("write_latency", cyc, 43);
    check("write_wr_pulses", wr_pulses - wr0, 1);
    check("write_rd_pulses", rd_pulses - rd0, 0);
    check("write_wdata", wdata_at_start, 16'h1234);
    check("write_mem_addr", bus.mem_addr, 16'h0200);
    check("write_rdata_kept", bus.rdata, 16'hBEEF);

    // Read back 0x0200
    @(negedge clk);
    bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 16'h0200;
    wait_ack(1'b1, cyc, wrong);
    bus.data_req = 1'b0;
    check("readback_latency", cyc, 43);
    check("readback_rdata", bus.rdata, 16'h1234);

    // Simultaneous requests: data first, fetch one IDLE cycle later
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'h0100;
    bus.data_req  = 1'b1; bus.data_we = 1'b0; bus.data_addr = 16'h0300;
    wait_ack(1'b1, cyc, wrong);
    bus.data_req = 1'b0;
    check("sim_data_latency", cyc, 43);
    check("sim_data_first", wrong, 0);
    check("sim_data_rdata", bus.rdata, 16'h5A5A);
    wait_ack(1'b0, cyc, wrong);
    bus.fetch_req = 1'b0;
    check("sim_fetch_latency", cyc, 44);
    check("sim_fetch_no_data", wrong, 0);
    check("sim_fetch_rdata", bus.rdata, 16'hBEEF);

    // Busy high in IDLE: must not issue until busy drops
    @(negedge clk);
    busy_force = 1'b1;
    rd0 = rd_pulses; a0 = ack_cnt;
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'h0200;
    repeat (6) @(negedge clk);
    check("busy_idle_no_start", rd_pulses - rd0, 0);
    check("busy_idle_no_ack", ack_cnt - a0, 0);
    busy_force = 1'b0;
    wait_ack(1'b0, cyc, wrong);
    bus.fetch_req = 1'b0;
    check("busy_idle_latency", cyc, 43);
    check("busy_idle_rdata", bus.rdata, 16'h1234);

    // Reset in WAIT cycle 10
    @(negedge clk);
    a0 = ack_cnt;
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'h0300;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    bus.fetch_req = 1'b0;
    @(negedge clk);
    check("midrst_fetch_ack", bus.fetch_ack, 0);
    check("midrst_data_ack",  bus.data_ack, 0);
    check("midrst_start",     {bus.mem_start_read, bus.mem_start_write}, 0);
    check("midrst_rdata",     bus.rdata, 0);
    check("midrst_mem_addr",  bus.mem_addr, 0);
    check("midrst_mem_wdata", bus.mem_wdata, 0);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("midrst_no_ack", ack_cnt - a0, 0);
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'h0100;
    wait_ack(1'b0, cyc, wrong);
    bus.fetch_req = 1'b0;
    check("postrst_latency", cyc, 43);
    check("postrst_rdata", bus.rdata, 16'hBEEF);

    // Both requests held for four transactions
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.fetch_req = 1'b1; bus.fetch_addr = 16'h0100;
    bus.data_req  = 1'b1; bus.data_we = 1'b0; bus.data_addr = 16'h0300;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      forever begin
        @(negedge clk);
        cyc++;
        if (bus.fetch_ack || bus.data_ack || cyc >= 200) break;
      end
      who = bus.data_ack;
      if (k == 3) begin
        bus.fetch_req = 1'b0;
        bus.data_req  = 1'b0;
      end
`ifdef RR_ARB_EN
      exp_who = (k % 2 == 0);
`else
      exp_who = 1'b1;
`endif
      check($sformatf("cont_grant%0d", k), who, exp_who);
      check($sformatf("cont_gap%0d", k), cyc, (k == 0) ? 43 : 44);
    end

    repeat (3) @(negedge clk);
    check("protocol_violations", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
